// File: rtl/bioz_iq_demod.sv
// Synchronous I/Q correlator for bio-impedance: multiplies ADC samples by the +/-1 reference
// phases over a window of 2^PeriodSel reference periods and reports the two saturated sums.
module bioz_iq_demod (
    input  logic        Clk,
    input  logic        Resetn,
    input  logic        Enable,
    input  logic        Start,
    input  logic        Continuous,
    input  logic [2:0]  PeriodSel,
    input  logic        IP,
    input  logic        QP,
    input  logic        SampleValid,
    input  logic [15:0] SampleData,
    output logic [23:0] IOut,
    output logic [23:0] QOut,
    output logic [15:0] SampleCount,
    output logic        OutValid,
    output logic        Ovf,
    output logic        Busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_ACCUM = 2'd2
    } state_t;

    // Returns {overflowed, acc +/- smp clamped to the 24-bit signed range}.
    function automatic logic [24:0] sat_acc(input logic [23:0] acc,
                                            input logic [15:0] smp,
                                            input logic        add);
        logic [24:0] a;
        logic [24:0] s;
        logic [24:0] sum;
        a   = {acc[23], acc};
        s   = {{9{smp[15]}}, smp};
        sum = add ? (a + s) : (a - s);
        if (sum[24] != sum[23]) begin
            return {1'b1, sum[24], {23{~sum[24]}}};
        end
        return {1'b0, sum[23:0]};
    endfunction

    state_t      state_q, state_d;
    logic        ip_meta_q, ip_meta_d;
    logic        ip_sync_q, ip_sync_d;
    logic        ip_prev_q, ip_prev_d;
    logic        qp_meta_q, qp_meta_d;
    logic        qp_sync_q, qp_sync_d;
    logic [23:0] acc_i_q, acc_i_d;
    logic [23:0] acc_q_q, acc_q_d;
    logic [15:0] samp_cnt_q, samp_cnt_d;
    logic [7:0]  per_cnt_q, per_cnt_d;
    logic        win_ovf_q, win_ovf_d;
    logic [23:0] i_out_q, i_out_d;
    logic [23:0] q_out_q, q_out_d;
    logic [15:0] cnt_out_q, cnt_out_d;
    logic        ovf_out_q, ovf_out_d;
    logic        out_vld_q, out_vld_d;
    logic        busy_q, busy_d;

    logic        ref_edge;
    logic [24:0] i_run, q_run, i_first, q_first;
    logic [23:0] first_i, first_q;
    logic [15:0] first_cnt, cnt_inc;
    logic        first_ovf;
    logic [7:0]  per_cnt_inc, n_per;

    assign ref_edge = ip_sync_q & ~ip_prev_q;

    always_comb begin
        ip_meta_d = IP;
        ip_sync_d = ip_meta_q;
        ip_prev_d = ip_sync_q;
        qp_meta_d = QP;
        qp_sync_d = qp_meta_q;

        i_run   = sat_acc(acc_i_q, SampleData, ip_sync_q);
        q_run   = sat_acc(acc_q_q, SampleData, qp_sync_q);
        i_first = sat_acc(24'd0, SampleData, ip_sync_q);
        q_first = sat_acc(24'd0, SampleData, qp_sync_q);

        // Values a window starts with: the sample on the opening edge is its first sample.
        first_i   = SampleValid ? i_first[23:0] : 24'd0;
        first_q   = SampleValid ? q_first[23:0] : 24'd0;
        first_cnt = SampleValid ? 16'd1 : 16'd0;
        first_ovf = SampleValid & (i_first[24] | q_first[24]);

        cnt_inc     = (samp_cnt_q == 16'hFFFF) ? samp_cnt_q : samp_cnt_q + 16'd1;
        per_cnt_inc = per_cnt_q + 8'd1;
        n_per       = 8'd1 << PeriodSel;

        state_d    = state_q;
        acc_i_d    = acc_i_q;
        acc_q_d    = acc_q_q;
        samp_cnt_d = samp_cnt_q;
        per_cnt_d  = per_cnt_q;
        win_ovf_d  = win_ovf_q;
        i_out_d    = i_out_q;
        q_out_d    = q_out_q;
        cnt_out_d  = cnt_out_q;
        ovf_out_d  = ovf_out_q;
        out_vld_d  = 1'b0;

        if (!Enable) begin
            state_d    = S_IDLE;
            acc_i_d    = 24'd0;
            acc_q_d    = 24'd0;
            samp_cnt_d = 16'd0;
            per_cnt_d  = 8'd0;
            win_ovf_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Start || Continuous) begin
                        state_d = S_ARM;
                    end
                end
                S_ARM: begin
                    if (ref_edge) begin
                        state_d    = S_ACCUM;
                        acc_i_d    = first_i;
                        acc_q_d    = first_q;
                        samp_cnt_d = first_cnt;
                        per_cnt_d  = 8'd0;
                        win_ovf_d  = first_ovf;
                    end
                end
                S_ACCUM: begin
                    if (ref_edge && (per_cnt_inc == n_per)) begin
                        // Report excludes the closing-cycle sample; it belongs to the next window.
                        i_out_d   = acc_i_q;
                        q_out_d   = acc_q_q;
                        cnt_out_d = samp_cnt_q;
                        ovf_out_d = win_ovf_q;
                        out_vld_d = 1'b1;
                        if (Continuous) begin
                            acc_i_d    = first_i;
                            acc_q_d    = first_q;
                            samp_cnt_d = first_cnt;
                            per_cnt_d  = 8'd0;
                            win_ovf_d  = first_ovf;
                        end else begin
                            state_d    = S_IDLE;
                            acc_i_d    = 24'd0;
                            acc_q_d    = 24'd0;
                            samp_cnt_d = 16'd0;
                            per_cnt_d  = 8'd0;
                            win_ovf_d  = 1'b0;
                        end
                    end else begin
                        if (ref_edge) begin
                            per_cnt_d = per_cnt_inc;
                        end
                        if (SampleValid) begin
                            acc_i_d    = i_run[23:0];
                            acc_q_d    = q_run[23:0];
                            samp_cnt_d = cnt_inc;
                            win_ovf_d  = win_ovf_q | i_run[24] | q_run[24];
                        end
                    end
                end
                default: begin
                    state_d    = S_IDLE;
                    acc_i_d    = 24'd0;
                    acc_q_d    = 24'd0;
                    samp_cnt_d = 16'd0;
                    per_cnt_d  = 8'd0;
                    win_ovf_d  = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= S_IDLE;
            ip_meta_q  <= 1'b0;
            ip_sync_q  <= 1'b0;
            ip_prev_q  <= 1'b0;
            qp_meta_q  <= 1'b0;
            qp_sync_q  <= 1'b0;
            acc_i_q    <= 24'd0;
            acc_q_q    <= 24'd0;
            samp_cnt_q <= 16'd0;
            per_cnt_q  <= 8'd0;
            win_ovf_q  <= 1'b0;
            i_out_q    <= 24'd0;
            q_out_q    <= 24'd0;
            cnt_out_q  <= 16'd0;
            ovf_out_q  <= 1'b0;
            out_vld_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ip_meta_q  <= ip_meta_d;
            ip_sync_q  <= ip_sync_d;
            ip_prev_q  <= ip_prev_d;
            qp_meta_q  <= qp_meta_d;
            qp_sync_q  <= qp_sync_d;
            acc_i_q    <= acc_i_d;
            acc_q_q    <= acc_q_d;
            samp_cnt_q <= samp_cnt_d;
            per_cnt_q  <= per_cnt_d;
            win_ovf_q  <= win_ovf_d;
            i_out_q    <= i_out_d;
            q_out_q    <= q_out_d;
            cnt_out_q  <= cnt_out_d;
            ovf_out_q  <= ovf_out_d;
            out_vld_q  <= out_vld_d;
            busy_q     <= busy_d;
        end
    end

    assign IOut        = i_out_q;
    assign QOut        = q_out_q;
    assign SampleCount = cnt_out_q;
    assign Ovf         = ovf_out_q;
    assign OutValid    = out_vld_q;
    assign Busy        = busy_q;

endmodule

// File: tb/tb_bioz_iq_demod.sv
// Bench for bioz_iq_demod: directed vector table, corner-case sequences and random windows
// checked against a window-level model evaluated over the recorded input history.
module tb_bioz_iq_demod;

    logic        Clk = 1'b0;
    logic        Resetn, Enable, Start, Continuous;
    logic [2:0]  PeriodSel;
    logic        IP, QP, SampleValid;
    logic [15:0] SampleData;
    logic [23:0] IOut, QOut;
    logic [15:0] SampleCount;
    logic        OutValid, Ovf, Busy;

    bioz_iq_demod dut (
        .Clk(Clk), .Resetn(Resetn), .Enable(Enable), .Start(Start),
        .Continuous(Continuous), .PeriodSel(PeriodSel), .IP(IP), .QP(QP),
        .SampleValid(SampleValid), .SampleData(SampleData), .IOut(IOut),
        .QOut(QOut), .SampleCount(SampleCount), .OutValid(OutValid),
        .Ovf(Ovf), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam int MAXK = 40000;

    int n_checks = 0;
    int n_fail   = 0;

    // Inputs as seen by the DUT at clock edge k.
    bit ip_a [MAXK];
    bit qp_a [MAXK];
    bit sv_a [MAXK];
    int sd_a [MAXK];
    bit en_a [MAXK];
    bit st_a [MAXK];
    bit ct_a [MAXK];
    int ps_a [MAXK];
    int k = 0;

    typedef struct {
        int k;
        int i;
        int q;
        int cnt;
        int ovf;
    } ev_t;

    ev_t dut_q[$];
    ev_t mdl_q[$];

    int ref_per = 32;
    int phase   = 0;
    int dmode   = 0;   // 0 follows sIP with +/-amp, 1 constant amp, 2 random
    int vmode   = 0;   // 0 every cycle, 1 alternate cycles, 2 random
    int amp     = 100;
    bit alt_tog = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        int sd;
        ev_t e;
        @(posedge Clk);
        k++;
        if (k >= MAXK) begin
            $display("FAIL cycle_budget: k=%0d exceeds %0d", k, MAXK);
            $fatal(1, "budget");
        end
        ip_a[k] = IP;
        qp_a[k] = QP;
        sv_a[k] = SampleValid;
        sd_a[k] = int'($signed(SampleData));
        en_a[k] = Enable;
        st_a[k] = Start;
        ct_a[k] = Continuous;
        ps_a[k] = int'(PeriodSel);
        #1;
        if (OutValid) begin
            e.k   = k;
            e.i   = int'($signed(IOut));
            e.q   = int'($signed(QOut));
            e.cnt = int'(SampleCount);
            e.ovf = int'(Ovf);
            dut_q.push_back(e);
        end
        phase = (phase + 1) % ref_per;
        IP    = (phase < ref_per / 2);
        QP    = (((phase - ref_per / 4 + ref_per) % ref_per) < ref_per / 2);
        Start = 1'b0;
        case (vmode)
            0:       SampleValid = 1'b1;
            1:       begin alt_tog = ~alt_tog; SampleValid = alt_tog; end
            default: SampleValid = ($urandom_range(0, 3) != 0);
        endcase
        // Next edge sees sIP equal to IP recorded one edge ago.
        case (dmode)
            0:       sd = ip_a[k-1] ? amp : -amp;
            1:       sd = amp;
            default: sd = int'($urandom_range(0, 65535)) - 32768;
        endcase
        SampleData = sd[15:0];
    endtask

    function automatic bit edge_at(input int j);
        if (j < 3) return 1'b0;
        return ip_a[j-2] && !ip_a[j-3];
    endfunction

    function automatic int clamp(input int v, output bit hit);
        hit = 1'b0;
        if (v > 8388607)  begin hit = 1'b1; return 8388607; end
        if (v < -8388608) begin hit = 1'b1; return -8388608; end
        return v;
    endfunction

    // Window-level reference: find arm points, opening edges and the Nth following edge,
    // then sum the signed samples between opening and closing edges.
    task automatic run_model(input int kb, input int ke);
        int  kk, ks, kc, n, e, ai, aq, cnt, ov, sgn_i, sgn_q;
        bit  aborted, done, hit;
        ev_t ev;
        kk   = kb;
        done = 1'b0;
        while (kk <= ke && !done) begin
            if (!(en_a[kk] && (st_a[kk] || ct_a[kk]))) begin
                kk++;
            end else begin
                ks = kk + 1;
                while (ks <= ke && en_a[ks] && !edge_at(ks)) ks++;
                if (ks > ke) begin
                    done = 1'b1;
                end else if (!en_a[ks]) begin
                    kk = ks + 1;
                end else begin
                    aborted = 1'b0;
                    while (!aborted && !done) begin
                        n  = 1 << ps_a[ks];
                        e  = 0;
                        kc = ks + 1;
                        while (kc <= ke) begin
                            if (!en_a[kc]) begin aborted = 1'b1; break; end
                            if (edge_at(kc)) begin
                                e++;
                                if (e == n) break;
                            end
                            kc++;
                        end
                        if (kc > ke) begin
                            done = 1'b1;
                        end else if (aborted) begin
                            kk = kc + 1;
                        end else begin
                            ai = 0; aq = 0; cnt = 0; ov = 0;
                            for (int j = ks; j < kc; j++) begin
                                if (sv_a[j]) begin
                                    sgn_i = ip_a[j-2] ? sd_a[j] : -sd_a[j];
                                    sgn_q = qp_a[j-2] ? sd_a[j] : -sd_a[j];
                                    ai = clamp(ai + sgn_i, hit); if (hit) ov = 1;
                                    aq = clamp(aq + sgn_q, hit); if (hit) ov = 1;
                                    if (cnt < 65535) cnt++;
                                end
                            end
                            ev.k = kc; ev.i = ai; ev.q = aq; ev.cnt = cnt; ev.ovf = ov;
                            mdl_q.push_back(ev);
                            if (ct_a[kc]) begin
                                ks = kc;
                            end else begin
                                kk = kc + 1;
                                aborted = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic compare_queues(input string tag);
        check({tag, ".events"}, dut_q.size(), mdl_q.size());
        for (int i = 0; i < dut_q.size() && i < mdl_q.size(); i++) begin
            check({tag, ".cycle"}, dut_q[i].k,   mdl_q[i].k);
            check({tag, ".iout"},  dut_q[i].i,   mdl_q[i].i);
            check({tag, ".qout"},  dut_q[i].q,   mdl_q[i].q);
            check({tag, ".count"}, dut_q[i].cnt, mdl_q[i].cnt);
            check({tag, ".ovf"},   dut_q[i].ovf, mdl_q[i].ovf);
        end
    endtask

    task automatic run_case(input int psel, input int cont, input int dm, input int vm,
                            input int a, input int ncyc, input int per, input int glitch_at,
                            input string tag);
        int kb;
        dut_q.delete();
        mdl_q.delete();
        ref_per    = per;
        phase      = phase % per;
        dmode      = dm;
        vmode      = vm;
        amp        = a;
        PeriodSel  = 3'(psel);
        Continuous = (cont != 0);
        Enable     = 1'b1;
        Start      = 1'b1;
        kb         = k + 1;
        for (int i = 0; i < ncyc; i++) begin
            Enable = (i != glitch_at);
            tick();
        end
        Enable     = 1'b0;
        Continuous = 1'b0;
        repeat (3) tick();
        run_model(kb, k);
        compare_queues(tag);
    endtask

    typedef struct {
        int psel; int cont; int dm; int vm; int amp; int ncyc;
        int exp_n; int exp_i; int exp_q; int exp_cnt; int exp_ovf;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int  ks0, got, a;
        vecs[0] = '{2, 0, 0, 0, 100,   200, 1,  12800,   0, 128, 0};
        vecs[1] = '{0, 1, 1, 0, 500,   320, -1, 0,       0, 32,  0};
        vecs[2] = '{3, 0, 0, 0, 32767, 330, 1,  8388352, 0, 256, 0};
        vecs[3] = '{4, 0, 0, 0, 32767, 600, 1,  8388607, 0, 512, 1};
        vecs[4] = '{0, 0, 0, 1, 100,   80,  1,  1600,    0, 16,  0};

        Resetn = 1'b0; Enable = 1'b0; Start = 1'b0; Continuous = 1'b0;
        PeriodSel = 3'd0; IP = 1'b0; QP = 1'b0; SampleValid = 1'b0; SampleData = 16'd0;
        repeat (4) tick();
        check("rst.iout",  IOut, 0);
        check("rst.qout",  QOut, 0);
        check("rst.count", SampleCount, 0);
        check("rst.outvld", OutValid, 0);
        check("rst.ovf",   Ovf, 0);
        check("rst.busy",  Busy, 0);
        Resetn = 1'b1;
        repeat (6) tick();
        check("idle.busy", Busy, 0);

        for (int v = 0; v < 5; v++) begin
            run_case(vecs[v].psel, vecs[v].cont, vecs[v].dm, vecs[v].vm, vecs[v].amp,
                     vecs[v].ncyc, 32, -1, $sformatf("vec%0d", v));
            if (vecs[v].exp_n >= 0) check($sformatf("vec%0d.n", v), dut_q.size(), vecs[v].exp_n);
            else check($sformatf("vec%0d.n_min", v), (dut_q.size() >= 8), 1);
            for (int i = 0; i < dut_q.size(); i++) begin
                check($sformatf("vec%0d.i", v),   dut_q[i].i,   vecs[v].exp_i);
                check($sformatf("vec%0d.q", v),   dut_q[i].q,   vecs[v].exp_q);
                check($sformatf("vec%0d.cnt", v), dut_q[i].cnt, vecs[v].exp_cnt);
                check($sformatf("vec%0d.ovf", v), dut_q[i].ovf, vecs[v].exp_ovf);
                if (vecs[v].cont != 0 && i > 0)
                    check($sformatf("vec%0d.gap", v), dut_q[i].k - dut_q[i-1].k, 32);
            end
            check($sformatf("vec%0d.idle", v), Busy, 0);
        end

        // Enable dropped 20 cycles into an 8-period window: outputs of the prior window hold.
        run_case(2, 0, 0, 0, 100, 200, 32, -1, "pre_drop");
        dut_q.delete();
        dmode = 1; amp = 300; vmode = 0;
        PeriodSel = 3'd3; Enable = 1'b1; Start = 1'b1;
        tick();
        ks0 = k;
        got = 0;
        for (int t = 0; t < 100 && got == 0; t++) begin
            tick();
            if (Busy && edge_at(k) && k > ks0) got = 1;
        end
        check("drop.arm_seen", got, 1);
        repeat (20) tick();
        check("drop.busy_before", Busy, 1);
        Enable = 1'b0;
        tick();
        check("drop.busy", Busy, 0);
        check("drop.iout_hold", int'($signed(IOut)), 12800);
        check("drop.qout_hold", int'($signed(QOut)), 0);
        check("drop.cnt_hold", SampleCount, 128);
        check("drop.ovf_hold", Ovf, 0);
        repeat (300) tick();
        check("drop.no_outvld", dut_q.size(), 0);

        // Start pulses while busy are ignored: a single window results.
        dut_q.delete(); mdl_q.delete();
        dmode = 0; amp = 100; vmode = 0;
        PeriodSel = 3'd1; Continuous = 1'b0; Enable = 1'b1; Start = 1'b1;
        ks0 = k + 1;
        tick();
        repeat (15) tick();
        check("restart.busy1", Busy, 1);
        Start = 1'b1; tick();
        repeat (40) tick();
        check("restart.busy2", Busy, 1);
        Start = 1'b1; tick();
        repeat (100) tick();
        Enable = 1'b0;
        repeat (3) tick();
        run_model(ks0, k);
        compare_queues("restart");
        check("restart.n", dut_q.size(), 1);
        if (dut_q.size() == 1) check("restart.i", dut_q[0].i, 6400);

        // Asynchronous reset in the middle of a window clears everything at once.
        Enable = 1'b1; Start = 1'b1; PeriodSel = 3'd2;
        repeat (60) tick();
        Resetn = 1'b0;
        #2;
        check("amid.iout",   IOut, 0);
        check("amid.qout",   QOut, 0);
        check("amid.count",  SampleCount, 0);
        check("amid.ovf",    Ovf, 0);
        check("amid.outvld", OutValid, 0);
        check("amid.busy",   Busy, 0);
        Enable = 1'b0;
        repeat (3) tick();
        Resetn = 1'b1;
        repeat (6) tick();

        for (int r = 0; r < 12; r++) begin
            int per, ps, nc, gl;
            per = 4 * int'($urandom_range(3, 12));
            ps  = int'($urandom_range(0, 3));
            nc  = per * (1 << ps) * 2 + 2 * per + 20;
            gl  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nc - 1)) : -1;
            a   = int'($urandom_range(1, 32767));
            run_case(ps, int'($urandom_range(0, 1)), ($urandom_range(0, 1) == 0) ? 0 : 2,
                     int'($urandom_range(0, 2)), a, nc, per, gl, $sformatf("rnd%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
